// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a prefetch FIFO and branch squash.
//
// Issues sequential fetches to a synchronous instruction RAM and captures each
// response one cycle later into a DEPTH-entry FIFO of {instruction, PC}. A taken
// branch flushes the FIFO, squashes the in-flight response and redirects the
// fetch PC. The decoder drains the head over a valid/ready handshake.
//
// Optional feature: define FETCHQ_PERF_EN to build the saturating performance
// counters; otherwise perf_fetched/perf_squashed are tied to zero.
//
// Ports:
//   clk, nreset           clock, asynchronous active-low reset
//   imem_req, imem_addr   fetch request and address to the instruction RAM
//   imem_data             RAM read data, one cycle after the request
//   br_valid, br_target   taken-branch redirect
//   out_valid, out_ready  head handshake to the decoder
//   out_instr, out_pc     head instruction and its address
//   out_link              out_pc + INSTR_W/8 (branch-and-link return address)
//   occupancy             valid FIFO entries
//   perf_fetched          handshake count (saturating)
//   perf_squashed         squashed response + flushed entry count (saturating)
module fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       nreset,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_data,
    input  logic                       br_valid,
    input  logic [ADDR_W-1:0]          br_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_link,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [15:0]                perf_fetched,
    output logic [15:0]                perf_squashed
);

    localparam int unsigned       PTR_W  = $clog2(DEPTH);
    localparam int unsigned       CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INSTR_W / 8);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];

    logic push, pop, room;

    // Only the word-aligned part of the branch target is used.
    logic unused_br_lsb;
    assign unused_br_lsb = ^br_target[1:0];

    assign out_valid = (count_q != '0);
    assign out_instr = instr_mem[rd_ptr_q];
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_link  = pc_mem[rd_ptr_q] + PC_INC;
    assign occupancy = count_q;
    assign imem_addr = fetch_pc_q;

    assign pop  = out_valid && out_ready;
    // A response arriving during a branch cycle belongs to the wrong path.
    assign push = inflight_q && !br_valid;
    // The in-flight slot is reserved so a returning response always fits.
    assign room = (count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH);
    assign imem_req = nreset && !br_valid && room;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = fetch_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (br_valid) begin
            fetch_pc_d = {br_target[ADDR_W-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + PC_INC;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed when counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_data;
            pc_mem[wr_ptr_q]    <= inflight_pc_q;
        end
    end

`ifdef FETCHQ_PERF_EN
    logic [15:0]      perf_fetched_q, perf_fetched_d;
    logic [15:0]      perf_squashed_q, perf_squashed_d;
    logic [CNT_W-1:0] squash_cnt;
    logic [16:0]      squash_sum;

    // The entry popped in a branch cycle goes to the consumer, not the flush.
    assign squash_cnt = br_valid ? (count_q + CNT_W'(inflight_q) - CNT_W'(pop)) : '0;
    assign squash_sum = {1'b0, perf_squashed_q} + 17'(squash_cnt);

    always_comb begin
        perf_fetched_d  = perf_fetched_q;
        perf_squashed_d = squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
        if (pop && (perf_fetched_q != 16'hFFFF)) begin
            perf_fetched_d = perf_fetched_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`else
    assign perf_fetched  = 16'h0000;
    assign perf_squashed = 16'h0000;
`endif

endmodule
